serial_comp_sequencer: RTL

SERIAL_COMP_SEQUENCER -- requirements
Module: serial_comp_sequencer

---
 rtl/serial_comp_pkg.sv | 15 +
 rtl/serial_comp_sequencer_if.sv | 30 +++
 rtl/serial_capture_reg.sv | 32 +++
 rtl/serial_comp_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the serial two's-complement sequencer.
//   state_e             : sequencer FSM states
//   SERIAL_COMP_WIDTH   : default word width
package serial_comp_pkg;

  localparam int unsigned SERIAL_COMP_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/serial_comp_sequencer_if.sv
// Upstream/downstream handshake bundle of the serial two's-complement sequencer.
//   in_valid/in_ready/in_data      : word request from upstream
//   out_valid/out_ready/out_data   : complemented result to downstream
//   out_err                        : result self-check flag
// master = traffic source/sink (testbench or surrounding logic), slave = sequencer.
interface serial_comp_sequencer_if
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_COMP_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/serial_capture_reg.sv
// Serial-to-parallel capture register: shifts a new bit in at the MSB on each
// enabled edge, so an LSB-first stream ends up in natural bit order.
//   clk, rst_n : clock, asynchronous active-low clear
//   en_i       : shift enable
//   bit_i      : serial bit entering at the MSB
//   q_o        : parallel register contents
module serial_capture_reg
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_COMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Right shift with the incoming bit at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {bit_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_comp_sequencer.sv
// Sequencer driving an external Serial_twosComplementer: accepts one word,
// parallel-loads it, shifts it WIDTH times while capturing the serial result,
// then presents the parallel two's complement downstream.
//   Clock, reset_b     : clock, asynchronous active-low reset
//   bus (slave)        : in_valid/in_ready/in_data, out_valid/out_ready/out_data, out_err
//   data               : parallel word to the complementer
//   load               : complementer parallel-load strobe
//   shift_control      : complementer shift enable
//   y                  : serial complemented bit, LSB first
// Optional feature: define SERIAL_COMP_CHECK_EN to compare the captured result
// against (~data + 1) and flag differences on out_err.
module serial_comp_sequencer
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_COMP_WIDTH
) (
  input  logic                    Clock,
  input  logic                    reset_b,
  serial_comp_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]        data,
  output logic                    load,
  output logic                    shift_control,
  input  logic                    y
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [WIDTH-1:0]   data_q,       data_d;
  logic               load_q,       load_d;
  logic               shift_q,      shift_d;
  logic               in_ready_q,   in_ready_d;
  logic               out_valid_q,  out_valid_d;
  logic [WIDTH-1:0]   capture;

  // State and registered output decodes.
  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      load_q      <= 1'b0;
      shift_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      load_q      <= load_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // alongside it and match the state in every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.in_data;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q counts completed shifts; this edge is the WIDTH-th one.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_d      = (state_d == LOAD);
    shift_d     = (state_d == SHIFT);
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // y is captured on exactly the edges where the complementer shifts.
  serial_capture_reg #(
    .WIDTH (WIDTH)
  ) u_capture (
    .clk   (Clock),
    .rst_n (reset_b),
    .en_i  (shift_q),
    .bit_i (y),
    .q_o   (capture)
  );

`ifdef SERIAL_COMP_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] capture_next;
  logic [WIDTH-1:0] expect_val;

  // The last shift lands on the DONE-entry edge, so compare against the
  // value the capture register is about to take.
  assign capture_next = {y, capture[WIDTH-1:1]};
  assign expect_val   = ~data_q + WIDTH'(1);

  always_comb begin
    err_d = 1'b0;
    if (state_q == SHIFT && state_d == DONE) begin
      err_d = (capture_next != expect_val);
    end else if (state_d == DONE) begin
      err_d = err_q;
    end
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = capture;
  assign data          = data_q;
  assign load          = load_q;
  assign shift_control = shift_q;

endmodule
